// File: rtl/syscall_ctrl.sv
// SYSCALL sequencing controller: print/exit handling, stall generation and run statistics.
// Optional pause service (code 50, resumed by the board button) is built when SYSCALL_PAUSE_EN is defined.
//
// state | meaning
// RUN   | normal execution, syscalls accepted
// HOLD  | post-print stall, counting down hold_cnt_q
// PAUSE | waiting for a resume button rise (SYSCALL_PAUSE_EN only)
// HALT  | exit executed, terminal until reset
module syscall_ctrl #(
  parameter int CNT_W       = 32,
  parameter int HOLD_CYCLES = 4,
  parameter int EXIT_CODE   = 10,
  parameter int PRINT_CODE  = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic             is_syscall,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  input  logic             resume,
  output logic             stall,
  output logic             halted,
  output logic [31:0]      disp,
  output logic             disp_upd,
  output logic             bad_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [15:0]      syscall_cnt
);

  typedef enum logic [1:0] {RUN, HOLD, PAUSE, HALT} state_e;

  localparam logic [31:0] EXIT_V    = 32'(EXIT_CODE);
  localparam logic [31:0] PRINT_V   = 32'(PRINT_CODE);
  localparam logic [7:0]  HOLD_INIT = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;
`ifdef SYSCALL_PAUSE_EN
  localparam logic [31:0] PAUSE_V   = 32'd50;
`endif

  state_e           state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [31:0]      disp_q, disp_d;
  logic             disp_upd_q, disp_upd_d;
  logic             bad_code_q, bad_code_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0]      syscall_cnt_q, syscall_cnt_d;
  logic             resume_q;
  logic             rise;
  logic             accept;

  assign rise   = resume & ~resume_q;
  assign accept = (state_q == RUN) && instr_valid && is_syscall;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    disp_d        = disp_q;
    disp_upd_d    = 1'b0;
    bad_code_d    = bad_code_q;
    cycle_cnt_d   = cycle_cnt_q;
    syscall_cnt_d = syscall_cnt_q;

    if (state_q != HALT && cycle_cnt_q != '1)
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);

    case (state_q)
      RUN: begin
        if (accept) begin
          if (syscall_cnt_q != 16'hFFFF)
            syscall_cnt_d = syscall_cnt_q + 16'd1;
          if (v0 == EXIT_V) begin
            state_d = HALT;
          end else if (v0 == PRINT_V) begin
            disp_d     = a0;
            disp_upd_d = 1'b1;
            if (HOLD_CYCLES > 0) begin
              state_d    = HOLD;
              hold_cnt_d = HOLD_INIT;
            end
          end
`ifdef SYSCALL_PAUSE_EN
          else if (v0 == PAUSE_V) begin
            state_d    = PAUSE;
            disp_d     = a0;
            disp_upd_d = 1'b1;
          end
`endif
          else begin
            bad_code_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_cnt_q == 8'd0)
          state_d = RUN;
        else
          hold_cnt_d = hold_cnt_q - 8'd1;
      end
      // Unreachable unless the pause service is built in.
      PAUSE: begin
        if (rise)
          state_d = RUN;
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      hold_cnt_q    <= 8'd0;
      disp_q        <= 32'd0;
      disp_upd_q    <= 1'b0;
      bad_code_q    <= 1'b0;
      cycle_cnt_q   <= '0;
      syscall_cnt_q <= 16'd0;
      resume_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      disp_q        <= disp_d;
      disp_upd_q    <= disp_upd_d;
      bad_code_q    <= bad_code_d;
      cycle_cnt_q   <= cycle_cnt_d;
      syscall_cnt_q <= syscall_cnt_d;
      resume_q      <= resume;
    end
  end

  assign stall       = (state_q != RUN);
  assign halted      = (state_q == HALT);
  assign disp        = disp_q;
  assign disp_upd    = disp_upd_q;
  assign bad_code    = bad_code_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign syscall_cnt = syscall_cnt_q;

endmodule

// File: tb/tb_syscall_ctrl.sv
// Scoreboard bench for syscall_ctrl: a cycle-indexed reference model pushes expected outputs,
// a negedge monitor pops and compares them. Honours SYSCALL_PAUSE_EN like the design.
module tb_syscall_ctrl;
  localparam int CNT_W = 6;
  localparam int HOLD  = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n, instr_valid, is_syscall, resume;
  logic [31:0]      v0, a0;
  logic             stall, halted, disp_upd, bad_code;
  logic [31:0]      disp;
  logic [CNT_W-1:0] cycle_cnt;
  logic [15:0]      syscall_cnt;

  syscall_ctrl #(.CNT_W(CNT_W), .HOLD_CYCLES(HOLD), .EXIT_CODE(10), .PRINT_CODE(34)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .is_syscall(is_syscall),
    .v0(v0), .a0(a0), .resume(resume), .stall(stall), .halted(halted), .disp(disp),
    .disp_upd(disp_upd), .bad_code(bad_code), .cycle_cnt(cycle_cnt), .syscall_cnt(syscall_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        stall, halted, upd, bad;
    logic [31:0] disp;
    int          cyc, sys;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  // Model: c is the cycle index since reset; a print in cycle c-1 stalls cycles c..c+HOLD-1.
  int          c, stall_until, m_cyc, m_sys;
  bit          m_halt, m_pause, m_bad, m_upd, last_res;
  logic [31:0] m_disp;

  function automatic bit m_stall();
    return m_halt || m_pause || (c <= stall_until);
  endfunction

  task automatic model_edge();
    bit was_stall, rise;
    exp_t e;
    if (!rst_n) begin
      c = 0; stall_until = -1; m_cyc = 0; m_sys = 0;
      m_halt = 0; m_pause = 0; m_bad = 0; m_upd = 0; m_disp = 32'd0;
      last_res = 0;
    end else begin
      was_stall = m_stall();
      rise = resume && !last_res;
      m_upd = 0;
      if (!m_halt && m_cyc < MAXC) m_cyc++;
      c++;
      if (m_pause && rise) m_pause = 0;
      if (!was_stall && instr_valid && is_syscall) begin
        if (m_sys < 16'hFFFF) m_sys++;
        if (v0 == 32'd10) m_halt = 1;
        else if (v0 == 32'd34) begin
          m_disp = a0; m_upd = 1; stall_until = c + HOLD - 1;
        end
`ifdef SYSCALL_PAUSE_EN
        else if (v0 == 32'd50) begin
          m_disp = a0; m_upd = 1; m_pause = 1;
        end
`endif
        else m_bad = 1;
      end
      last_res = resume;
    end
    e.stall = m_stall(); e.halted = m_halt; e.upd = m_upd; e.bad = m_bad;
    e.disp = m_disp; e.cyc = m_cyc; e.sys = m_sys;
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stall", 32'(stall), 32'(e.stall));
        chk("halted", 32'(halted), 32'(e.halted));
        chk("disp", disp, e.disp);
        chk("disp_upd", 32'(disp_upd), 32'(e.upd));
        chk("bad_code", 32'(bad_code), 32'(e.bad));
        chk("cycle_cnt", 32'(cycle_cnt), 32'(e.cyc));
        chk("syscall_cnt", 32'(syscall_cnt), 32'(e.sys));
      end
    end
  end

  task automatic cyc(input bit r, input bit iv, input bit sc, input logic [31:0] v,
                     input logic [31:0] a, input bit res);
    rst_n = r; instr_valid = iv; is_syscall = sc; v0 = v; a0 = a; resume = res;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input bit res);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 32'd0, 32'd0, res);
  endtask

  function automatic logic [31:0] pick_code();
    case ($urandom_range(0, 9))
      0:       return 32'd10;
      1, 2, 3: return 32'd34;
      4, 5:    return 32'd50;
      6:       return 32'd7;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit r;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'd34, 32'hDEADBEEF, 0);
    idle(6, 0);
    cyc(1, 1, 1, 32'd34, 32'h1234_5678, 0);
    idle(1, 0);
    cyc(1, 1, 1, 32'd34, 32'hCAFE_0000, 0);
    idle(5, 0);
    cyc(1, 1, 1, 32'd34, 32'h0BAD_F00D, 0);
    idle(1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    idle(2, 0);
    cyc(1, 0, 1, 32'd7, 32'h1, 0);
    cyc(1, 1, 1, 32'd7, 32'h2, 0);
    idle(3, 0);
    cyc(1, 1, 1, 32'd50, 32'h5050_5050, 1);
    idle(3, 1);
    idle(1, 0);
    idle(1, 1);
    idle(3, 0);
    cyc(1, 1, 1, 32'd10, 32'h0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 1, 32'd34, $urandom, i[0]);
    idle(60, 0);
    cyc(0, 0, 0, 0, 0, 0);
    idle(80, 0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 119) != 0);
      cyc(r, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, pick_code(), $urandom,
          $urandom_range(0, 2) == 0);
    end
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/syscall_ctrl.md
Name: syscall_ctrl

Overview:
- Sequencing controller for SYSCALL instructions flagged by the ALU decoder's syscall output.
- Samples the service code ($v0) and argument ($a0) on the syscall cycle.
- Drives a stall to PC/register-file write enables, latches the display register, and halts the core on exit.
- Also keeps run statistics (cycle and syscall counters) for the board display.

Parameters:
- CNT_W, 32: width of cycle counter.
- HOLD_CYCLES, 4: stall cycles after a print syscall; 0 = no stall; legal range 0..255.
- EXIT_CODE, 10: $v0 value that halts the core.
- PRINT_CODE, 34: $v0 value that latches $a0 to the display.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- instr_valid  in  1  current-cycle instruction is real (not bubble).
- is_syscall  in  1  decoder syscall flag for current instruction.
- v0  in  32  register $v0 read value.
- a0  in  32  register $a0 read value.
- resume  in  1  board "go" button, already debounced.
- stall  out  1  freeze PC and all architectural writes.
- halted  out  1  core has executed exit.
- disp  out  32  display register.
- disp_upd  out  1  one-cycle pulse when disp loads.
- bad_code  out  1  sticky: a syscall with an unsupported code was executed.
- cycle_cnt  out  CNT_W  cycles spent outside HALT.
- syscall_cnt  out  16  accepted syscalls.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. Reset overrides any state, including mid-HOLD or PAUSE.
- Reset values: state=RUN, stall=0, halted=0, disp=0, disp_upd=0, bad_code=0, cycle_cnt=0, syscall_cnt=0, hold counter=0, resume_q=0.
- States: RUN, HOLD, PAUSE (optional feature only), HALT. State is registered.
- stall = (state != RUN), combinational from state. The syscall instruction itself retires normally in its cycle; the PC advances past it. Stall begins the following cycle.
- Accept: a syscall is accepted on a rising edge when state==RUN, instr_valid=1 and is_syscall=1. is_syscall with instr_valid=0, or outside RUN, is ignored.
- syscall_cnt: +1 per accepted syscall, saturating at 0xFFFF.
- v0==EXIT_CODE: next state HALT and halted=1. HALT is terminal; only reset leaves it. resume is ignored in HALT.
- v0==PRINT_CODE: disp<=a0 and disp_upd=1 for exactly the next cycle.
  - HOLD_CYCLES>0: enter HOLD with counter=HOLD_CYCLES-1. Decrement each cycle; return to RUN on the cycle after the counter reaches 0. Stall is therefore exactly HOLD_CYCLES cycles.
  - HOLD_CYCLES=0: remain in RUN.
- Any other code: bad_code<=1 (sticky until reset). Remain in RUN; no stall.
- cycle_cnt: +1 every cycle state != HALT, including stalled cycles. Saturates at all-ones; never wraps. Frozen in HALT.
- resume edge detect: resume_q<=resume every cycle; rise = resume & ~resume_q. rise is used only in PAUSE; it is ignored in all other states.
- Comparisons are full 32-bit equality on v0; a0 is passed through unmodified.

Optional Feature:
- Macro: SYSCALL_PAUSE_EN.
- Defined:
  - Code 50 accepted in RUN enters PAUSE: stall=1, disp<=a0, disp_upd pulse.
  - PAUSE exits to RUN on the cycle after a resume rise.
  - A rise coincident with the entry edge does not count; resume must be seen low then high while in PAUSE.
  - cycle_cnt keeps counting during PAUSE.
- Undefined: no PAUSE state is built; code 50 sets bad_code like any unsupported code.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> all outputs 0, state RUN. Reset asserted mid-HOLD (cycle 2 of 4) -> stall=0 next cycle, disp=0.
- Print: v0=34, a0=0xDEADBEEF, syscall cycle t -> disp=0xDEADBEEF and disp_upd=1 at t+1 only; stall=1 for t+1..t+4, 0 at t+5; syscall_cnt=1.
- Exit: v0=10 at cycle t -> halted=1, stall=1 from t+1 onward; cycle_cnt frozen; resume pulses and further syscalls have no effect until reset.
- Filtering/unknown code: is_syscall=1 with instr_valid=0 -> nothing changes. v0=7 valid -> bad_code=1 sticky, stall stays 0, syscall_cnt=1.
- Saturation: CNT_W=4, run 20 cycles -> cycle_cnt holds at 15. A second print syscall while in HOLD is ignored; syscall_cnt is unchanged.
- SYSCALL_PAUSE_EN: v0=50 with resume held high -> stays in PAUSE; resume low then high -> RUN one cycle after the rise. Without the macro, v0=50 -> bad_code=1, no stall.
